svm_cascade_ctrl: RTL and testbench

SVM_CASCADE_CTRL -- requirements
Module: svm_cascade_ctrl

---
 rtl/svm_cascade_ctrl_if.sv | 30 +++
 rtl/svm_cascade_ctrl.sv | 135 +++++++++++++
 tb/tb_svm_cascade_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/svm_cascade_ctrl_if.sv
// Handshake and data bundle between the cascade controller and its
// kernel engine / coefficient ROM / bias table.
interface svm_cascade_ctrl_if #(
    parameter int XLEN_PIXEL = 8
);
    logic                      start;
    logic                      kernel_valid;
    logic [2*XLEN_PIXEL-1:0]   kernel_in;
    logic [2*XLEN_PIXEL-1:0]   alpha_in;
    logic [2*XLEN_PIXEL-1:0]   b_in;
    logic                      kernel_ready;
    logic [2:0]                stage_idx;
    logic [3:0]                sv_idx;
    logic                      busy;
    logic                      done;
    logic                      y_class;
    logic [2:0]                reject_stage;

    // Environment side: issues start, kernels, coefficients and biases.
    modport master (
        output start, kernel_valid, kernel_in, alpha_in, b_in,
        input  kernel_ready, stage_idx, sv_idx, busy, done, y_class, reject_stage
    );

    // Controller side.
    modport slave (
        input  start, kernel_valid, kernel_in, alpha_in, b_in,
        output kernel_ready, stage_idx, sv_idx, busy, done, y_class, reject_stage
    );
endinterface

// File: rtl/svm_cascade_ctrl.sv
// Cascaded SVM decision controller: per stage, accumulates alpha*kernel over
// the stage's support vectors, adds the stage bias and rejects on a negative
// decision value. Operands are sign-magnitude 8.8, the accumulator is
// two's complement with 16 fractional bits.
module svm_cascade_ctrl #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_SV     = 10,
    parameter int NUM_OF_STAGES = 4,
    parameter int ACC_W         = 28
) (
    input  logic               clk,
    input  logic               rst,
    svm_cascade_ctrl_if.slave  bus
);

    localparam int W  = 2 * XLEN_PIXEL;        // operand word width
    localparam int MW = W - 1;                  // magnitude width
    localparam int PW = 2 * MW;                 // magnitude product width
    localparam int EW = (ACC_W > PW) ? ACC_W : PW + 1;  // signed working width

    localparam logic [3:0] LAST_SV    = 4'(NUM_OF_SV - 1);
    localparam logic [2:0] LAST_STAGE = 3'(NUM_OF_STAGES - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCUM  = 3'd1;
    localparam logic [2:0] BIAS   = 3'd2;
    localparam logic [2:0] DECIDE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // Sign-magnitude product in accumulator format; a negative-zero operand
    // yields a zero magnitude, so the optional negation still gives 0.
    function automatic logic signed [ACC_W-1:0] sm_product(
        input logic [W-1:0] k,
        input logic [W-1:0] a
    );
        logic [PW-1:0]        mag;
        logic signed [EW-1:0] ext;
        mag = {{MW{1'b0}}, k[MW-1:0]} * {{MW{1'b0}}, a[MW-1:0]};
        ext = signed'({{(EW-PW){1'b0}}, mag});
        if (k[W-1] ^ a[W-1]) begin
            ext = -ext;
        end
        return signed'(ACC_W'(ext));
    endfunction

    // Bias realigned from 8 to 16 fractional bits, then signed.
    function automatic logic signed [ACC_W-1:0] sm_bias(
        input logic [W-1:0] b
    );
        logic signed [EW-1:0] ext;
        ext = signed'({{(EW-MW-XLEN_PIXEL){1'b0}}, b[MW-1:0], {XLEN_PIXEL{1'b0}}});
        if (b[W-1]) begin
            ext = -ext;
        end
        return signed'(ACC_W'(ext));
    endfunction

    logic [2:0]               state;
    logic signed [ACC_W-1:0]  acc;
    logic [2:0]               stage_idx;
    logic [3:0]               sv_idx;
    logic                     y_class;
    logic [2:0]               reject_stage;

    // Cascade sequencing, accumulation and final verdict registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            stage_idx    <= '0;
            sv_idx       <= '0;
            y_class      <= 1'b0;
            reject_stage <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= ACCUM;
                        acc          <= '0;
                        stage_idx    <= '0;
                        sv_idx       <= '0;
                        y_class      <= 1'b0;
                        reject_stage <= '0;
                    end
                end
                ACCUM: begin
                    // kernel_ready is high throughout ACCUM, so valid alone marks a transfer
                    if (bus.kernel_valid) begin
                        acc <= acc + sm_product(bus.kernel_in, bus.alpha_in);
                        if (sv_idx == LAST_SV) begin
                            state <= BIAS;
                        end else begin
                            sv_idx <= sv_idx + 4'd1;
                        end
                    end
                end
                BIAS: begin
                    acc   <= acc + sm_bias(bus.b_in);
                    state <= DECIDE;
                end
                DECIDE: begin
                    if (acc[ACC_W-1]) begin
                        state        <= DONE;
                        y_class      <= 1'b0;
                        reject_stage <= stage_idx;
                    end else if (stage_idx == LAST_STAGE) begin
                        state        <= DONE;
                        y_class      <= 1'b1;
                        reject_stage <= stage_idx;
                    end else begin
                        state     <= ACCUM;
                        stage_idx <= stage_idx + 3'd1;
                        sv_idx    <= '0;
                        acc       <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.kernel_ready = (state == ACCUM);
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.stage_idx    = stage_idx;
    assign bus.sv_idx       = sv_idx;
    assign bus.y_class      = y_class;
    assign bus.reject_stage = reject_stage;

endmodule

// File: tb/tb_svm_cascade_ctrl.sv
// Scoreboard bench for svm_cascade_ctrl: each classification pushes its
// expected verdict and done cycle; a monitor pops and compares on done.
module tb_svm_cascade_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    svm_cascade_ctrl_if bus ();

    svm_cascade_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         done_cyc;
        logic       y;
        logic [2:0] rej;
        string      name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] b_tab [8];
    logic [15:0] kern_const;
    logic [15:0] alpha_const;
    logic        use_tab;

    always @(posedge clk) cyc <= cyc + 1;

    // External ROM / bias table / kernel engine model
    always_comb begin
        bus.b_in      = b_tab[bus.stage_idx];
        bus.alpha_in  = use_tab ? {8'h00, bus.sv_idx, 4'h0} : alpha_const;
        bus.kernel_in = kern_const;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_y_class"}, 32'(bus.y_class), 32'(e.y));
                check({e.name, "_reject_stage"}, 32'(bus.reject_stage), 32'(e.rej));
                check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    task automatic set_b(input logic [15:0] all_v, input int idx, input logic [15:0] v);
        for (int i = 0; i < 8; i++) b_tab[i] = all_v;
        if (idx >= 0) b_tab[idx] = v;
    endtask

    // One classification; lat is the hand-computed start-to-done cycle count.
    // probe_n > 0 checks stage_idx == probe_stage that many cycles after start.
    task automatic run_class(input string name, input logic y, input logic [2:0] rej,
                             input int lat, input logic toggle,
                             input int probe_n, input logic [2:0] probe_stage);
        int  c;
        bit  seen;
        @(posedge clk); #1;
        c = cyc;
        bus.start = 1'b1;
        sb.push_back('{done_cyc: c + lat, y: y, rej: rej, name: name});
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (toggle) bus.kernel_valid = ((cyc - c) % 2 == 1);
            if (probe_n > 0 && cyc == c + probe_n)
                check({name, "_probe_stage_idx"}, 32'(bus.stage_idx), 32'(probe_stage));
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        bus.kernel_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit seen;
        rst              = 1'b1;
        bus.start        = 1'b1;
        bus.kernel_valid = 1'b1;
        kern_const       = 16'h0100;
        alpha_const      = 16'h0080;
        use_tab          = 1'b0;
        set_b(16'h8400, -1, 16'h0);

        // Reset state, with start asserted alongside rst
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_kernel_ready", 32'(bus.kernel_ready), 32'd0);
        check("rst_y_class", 32'(bus.y_class), 32'd0);
        check("rst_reject_stage", 32'(bus.reject_stage), 32'd0);
        check("rst_stage_idx", 32'(bus.stage_idx), 32'd0);
        check("rst_sv_idx", 32'(bus.sv_idx), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("start_with_rst_ignored", 32'(bus.busy), 32'd0);

        // +5.0 - 4.0 per stage: all pass
        run_class("all_pass", 1'b1, 3'd3, 49, 1'b0, 1, 3'd0);
        // Stage 1 bias -6.0: reject at stage 1
        set_b(16'h8400, 1, 16'h8600);
        run_class("reject_s1", 1'b0, 3'd1, 25, 1'b0, 0, 3'd0);
        // Stage 0 exact zero counts as pass
        set_b(16'h8400, 0, 16'h8500);
        run_class("zero_pass", 1'b1, 3'd3, 49, 1'b0, 13, 3'd1);
        // kernel_valid toggling: 39 stall cycles
        set_b(16'h8400, -1, 16'h0);
        run_class("toggle_kv", 1'b1, 3'd3, 88, 1'b1, 0, 3'd0);
        // Both operands negative -> positive product
        kern_const = 16'h8100; alpha_const = 16'h8080;
        run_class("neg_neg", 1'b1, 3'd3, 49, 1'b0, 0, 3'd0);
        // Negative kernel: -5.0 + 4.0 rejects at stage 0
        alpha_const = 16'h0080;
        set_b(16'h0400, -1, 16'h0);
        run_class("neg_kernel", 1'b0, 3'd0, 13, 1'b0, 0, 3'd0);
        // Negative-zero operands and bias contribute nothing
        kern_const = 16'h8000; alpha_const = 16'h8080;
        set_b(16'h8000, -1, 16'h0);
        run_class("neg_zero", 1'b1, 3'd3, 49, 1'b0, 0, 3'd0);
        // 3.0*0.5*10 = 15.0 against -15.0 passes; one LSB more rejects
        kern_const = 16'h0300; alpha_const = 16'h0080;
        set_b(16'h8F00, -1, 16'h0);
        run_class("fifteen_zero", 1'b1, 3'd3, 49, 1'b0, 0, 3'd0);
        set_b(16'h8F00, 0, 16'h8F01);
        run_class("fifteen_lsb", 1'b0, 3'd0, 13, 1'b0, 0, 3'd0);
        // Per-SV alpha i/16: sum 2.8125 against bias -2.8125
        kern_const = 16'h0100; use_tab = 1'b1;
        set_b(16'h82D0, -1, 16'h0);
        run_class("alpha_tab", 1'b1, 3'd3, 49, 1'b0, 0, 3'd0);
        set_b(16'h82D0, 2, 16'h82D1);
        run_class("alpha_tab_s2", 1'b0, 3'd2, 37, 1'b0, 0, 3'd0);
        use_tab = 1'b0; alpha_const = 16'h0080;
        set_b(16'h8400, -1, 16'h0);

        // Reset during stage 2 ACCUM
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.stage_idx == 3'd2) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reach_stage2", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_y_class", 32'(bus.y_class), 32'd0);
        check("midrst_stage_idx", 32'(bus.stage_idx), 32'd0);
        rst = 1'b0;
        run_class("after_rst", 1'b1, 3'd3, 49, 1'b0, 0, 3'd0);

        // start held high: back-to-back runs, one done each
        @(posedge clk); #1;
        c = cyc;
        bus.start = 1'b1;
        sb.push_back('{done_cyc: c + 49, y: 1'b1, rej: 3'd3, name: "held_1"});
        sb.push_back('{done_cyc: c + 99, y: 1'b1, rej: 3'd3, name: "held_2"});
        for (int n = 0; n < 150; n++) begin
            if (cyc >= c + 99) break;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("held_idle_after", 32'(bus.busy), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
